systolic_drain: RTL and testbench
=================================

# systolic_drain

Result-drain stage for the N×N systolic MAC array. On a `capture` pulse from the array controller it snapshots the full `c_in` result matrix. It then streams the elements out in row-major order over a valid/ready interface, tagging each with its row and column indices. The array can start the next accumulation pass as soon as the snapshot is taken, so compute overlaps with readout.

## Interface
Parameters:
- `N`, default 2: array dimension; the drain emits N*N elements per matrix.
- `DW`, default 32: element width.
- `IW`, default `$clog2(N)` (minimum 1): width of the row/column index.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high. This is already decided.
- `c_in` in `[N-1:0][N-1:0]` × DW: result matrix; `c_in[r][c]` is the PE at row r, column c.
- `capture` in 1: single-cycle request to snapshot `c_in`.
- `capture_ready` out 1: a `capture` in this cycle will be accepted.
- `out_data` out DW: current element.
- `out_row` out IW: row index of `out_data`.
- `out_col` out IW: column index of `out_data`.
- `out_last` out 1: high when `out_data` is element (N-1, N-1).
- `out_valid` out 1: `out_data`, `out_row`, `out_col` and `out_last` are valid.
- `out_ready` in 1: downstream accepts the element.
- `busy` out 1: high while a matrix is being streamed.
- `overflow` out 1: one-cycle pulse when a `capture` is dropped.

## Operation
- State machine with two states: IDLE and STREAM.
- Handshake: a transfer occurs in any cycle where `out_valid && out_ready` is high.
- `capture_ready` is high in either of two cases:
  - the state is IDLE;
  - the state is STREAM, `out_last` is high and `out_ready` is high.
- `capture_ready` depends combinationally on `out_ready`.
- Accepted capture (`capture && capture_ready`):
  - all N*N `c_in` words are registered into the snapshot bank;
  - the row/column counters are set to (0,0);
  - the next state is STREAM.
- IDLE → STREAM on an accepted capture.
- STREAM, on a transfer:
  - if the element is not the last: column increments; when the column wraps from N-1 to 0, row increments.
  - if the element is the last and a capture is accepted in the same cycle: stay in STREAM and reload from the new capture, with no bubble.
  - if the element is the last and no capture arrives: go to IDLE.
- STREAM with no transfer: hold the counters and all outputs.
- Output values:
  - `out_data = snap[row][col]`.
  - `out_valid = busy = (state == STREAM)`.
  - `out_last = (row == N-1 && col == N-1)`.
- Dropped capture: if `capture` is high while `capture_ready` is low, the request is ignored.
  - The snapshot and counters are unchanged.
  - `overflow` is registered high for exactly one cycle, in the cycle after the dropped capture.
- `c_in` is sampled only on accepted captures. Changes to `c_in` during STREAM never affect the output.
- Reset, at power-up or asserted mid-stream:
  - state goes to IDLE and the counters to (0,0);
  - the snapshot is cleared to 0;
  - `out_valid`, `busy` and `overflow` go to 0.
  - Any partially streamed matrix is discarded, with no further output.

## Timing
- Latency from capture to the first element: 1 cycle. A capture in cycle t gives `out_valid` in cycle t+1 with (0,0).
- Throughput: 1 element per cycle while `out_ready` is held high.
- One matrix occupies exactly N*N cycles when `out_ready` is held high.
- Back-to-back matrices run with zero idle cycles between them.
- Stability: while `out_valid && !out_ready`, all `out_*` signals hold their values, as AXI-stream-style rules require.
- All outputs are registered except `capture_ready`.

## Structure
- Shared package `systolic_pkg` holds:
  - `N` and `DW` defaults;
  - the state enum (IDLE, STREAM);
  - the typedef for the `[N-1:0][N-1:0][DW-1:0]` matrix, shared with the array and controller.
- One natural sub-module, `drain_rc_counter`:
  - inputs: enable, load-to-zero, wrap at N-1;
  - outputs: row, col and last.
- The snapshot bank and output mux stay in the top module.

## Test plan
All scenarios use N=2, DW=32.
- Basic drain: with `c_in` = {{0x11,0x22},{0x33,0x44}}, pulse `capture` and hold `out_ready`=1.
  - Required: outputs 0x11 (0,0), 0x22 (0,1), 0x33 (1,0), then 0x44 (1,1) with `out_last`.
  - The stream covers 4 consecutive cycles starting 1 cycle after the capture, followed by `busy`=0.
- Backpressure: deassert `out_ready` for 3 cycles while 0x22 is presented.
  - Required: 0x22, (0,1) is held stable for the whole stall, then the order completes unchanged.
- Back-to-back: pulse a second `capture` with `c_in` = {{0xA,0xB},{0xC,0xD}} in the same cycle as the 0x44 transfer.
  - Required: 0xA follows 0x44 in the next cycle with no gap, and `overflow` stays 0.
- Dropped capture: pulse `capture` while 0x22 is being streamed.
  - Required: `overflow` pulses high for 1 cycle and the stream continues 0x33, 0x44 unchanged.
  - `c_in` changes made mid-stream do not appear at the output.
- Reset mid-stream: assert `rst` asynchronously between clock edges after 0x22.
  - Required: `out_valid`, `busy` and `overflow` drop to 0 immediately.
  - After release, a new capture restarts cleanly at (0,0).

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared dimensions, drain state encoding and matrix type for the systolic array
package systolic_pkg;
  localparam int N_DEF = 2;
  localparam int DW_DEF = 32;
  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [N_DEF-1:0][N_DEF-1:0][DW_DEF-1:0] matrix_t;
endpackage

// File: rtl/drain_rc_counter.sv
// drain_rc_counter: row-major (row, col) walker over an N x N matrix
module drain_rc_counter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);
  localparam logic [IW-1:0] M = IW'(N - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      col <= (col == M) ? '0 : col + 1'b1;
      row <= (col != M) ? row : (row == M) ? '0 : row + 1'b1;
    end
  end
  assign last = (row == M) && (col == M);
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: snapshots the result matrix on capture and streams it out row-major over valid/ready
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0][N-1:0][DW-1:0]   c_in,
  input  logic                          capture,
  output logic                          capture_ready,
  output logic [DW-1:0]                 out_data,
  output logic [IW-1:0]                 out_row,
  output logic [IW-1:0]                 out_col,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          overflow
);
  state_t state;
  logic [N-1:0][N-1:0][DW-1:0] snap;
  logic xfer, accept;
  assign out_valid = (state == STREAM);
  assign busy = out_valid;
  assign xfer = out_valid && out_ready;
  // a capture landing on the final transfer reloads with no bubble
  assign capture_ready = (state == IDLE) || (out_valid && out_last && out_ready);
  assign accept = capture && capture_ready;
  assign out_data = snap[out_row][out_col];
  drain_rc_counter #(.N(N), .IW(IW)) u_rc (
    .clk(clk), .rst(rst), .en(xfer), .load(accept),
    .row(out_row), .col(out_col), .last(out_last)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= capture && !capture_ready;
      if (accept) snap <= c_in;
      state <= accept ? STREAM : (xfer && out_last) ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed stimulus with a queue-level reference model checked every cycle
module tb_systolic_drain;
  import systolic_pkg::*;
  logic clk = 0, rst = 1, capture = 0, out_ready = 1;
  matrix_t c_in = '0;
  logic capture_ready, out_last, out_valid, busy, overflow;
  logic [31:0] out_data;
  logic [0:0] out_row, out_col;
  int errors = 0, checks = 0;

  systolic_drain #(.N(2), .DW(32)) dut (
    .clk(clk), .rst(rst), .c_in(c_in), .capture(capture), .capture_ready(capture_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; int r; int c; bit l;} el_t;
  el_t q[$];
  bit exp_ovf = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: pending elements of the current matrix as a queue
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_ovf = 0;
    end else begin
      bit cr;
      cr = (q.size() == 0) || (q.size() == 1 && out_ready);
      exp_ovf = capture && !cr;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (capture && cr)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            q.push_back('{c_in[r][c], r, c, (r == 1 && c == 1)});
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(out_valid), 32'(q.size() > 0));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("capture_ready", 32'(capture_ready), 32'((q.size() == 0) || (q.size() == 1 && out_ready)));
    if (q.size() > 0) begin
      chk("data", out_data, q[0].d);
      chk("row", 32'(out_row), 32'(q[0].r));
      chk("col", 32'(out_col), 32'(q[0].c));
      chk("last", 32'(out_last), 32'(q[0].l));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input logic [31:0] d, input int r, input int c, input bit l);
    chk({n, "_valid"}, 32'(out_valid), 32'd1);
    chk({n, "_data"}, out_data, d);
    chk({n, "_rc"}, {30'd0, out_row, out_col}, 32'(r * 2 + c));
    chk({n, "_last"}, 32'(out_last), 32'(l));
  endtask

  task automatic load(input logic [31:0] a, b, c, d);
    c_in[0][0] = a; c_in[0][1] = b; c_in[1][0] = c; c_in[1][1] = d;
  endtask

  initial begin
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cr", 32'(capture_ready), 32'd1);
    // basic drain
    load(32'h11, 32'h22, 32'h33, 32'h44);
    capture = 1; cyc(); capture = 0;
    lit("b0", 32'h11, 0, 0, 0); cyc();
    lit("b1", 32'h22, 0, 1, 0); cyc();
    lit("b2", 32'h33, 1, 0, 0); cyc();
    lit("b3", 32'h44, 1, 1, 1); cyc();
    chk("b_idle", 32'(busy), 32'd0);
    // backpressure on 0x22
    capture = 1; cyc(); capture = 0;
    lit("p0", 32'h11, 0, 0, 0); cyc();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      lit("stall", 32'h22, 0, 1, 0); cyc();
    end
    out_ready = 1;
    lit("p1", 32'h22, 0, 1, 0); cyc();
    lit("p2", 32'h33, 1, 0, 0);
    load(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD); cyc();
    lit("p3", 32'h44, 1, 1, 1);
    // back-to-back capture on the last transfer
    load(32'hA, 32'hB, 32'hC, 32'hD);
    chk("b2b_cr", 32'(capture_ready), 32'd1);
    capture = 1; cyc(); capture = 0;
    lit("k0", 32'hA, 0, 0, 0);
    chk("k0_ovf", 32'(overflow), 32'd0); cyc();
    lit("k1", 32'hB, 0, 1, 0);
    // dropped capture mid-stream
    load(32'h55, 32'h66, 32'h77, 32'h88);
    capture = 1; cyc(); capture = 0;
    chk("drop_ovf", 32'(overflow), 32'd1);
    lit("k2", 32'hC, 1, 0, 0); cyc();
    chk("drop_ovf_end", 32'(overflow), 32'd0);
    lit("k3", 32'hD, 1, 1, 1); cyc();
    chk("k_idle", 32'(busy), 32'd0);
    // async reset mid-stream with overflow pending
    load(32'h11, 32'h22, 32'h33, 32'h44);
    capture = 1; cyc();
    lit("r0", 32'h11, 0, 0, 0); cyc(); capture = 0;
    lit("r1", 32'h22, 0, 1, 0);
    chk("r1_ovf", 32'(overflow), 32'd1);
    #2 rst = 1; #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    cyc(); rst = 0; cyc();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    load(32'hA, 32'hB, 32'hC, 32'hD);
    capture = 1; cyc(); capture = 0;
    lit("n0", 32'hA, 0, 0, 0); cyc();
    lit("n1", 32'hB, 0, 1, 0); cyc();
    lit("n2", 32'hC, 1, 0, 0); cyc();
    lit("n3", 32'hD, 1, 1, 1); cyc();
    chk("n_idle", 32'(busy), 32'd0);
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
